// File: rtl/mesh_term_fifo_bank.sv
// Bank of independent first-word-fall-through FIFOs, one per mesh terminal
// (2*ROWS + 2*COLUMNS channels), with a reject-newest or overwrite-oldest full policy.
module mesh_term_fifo_bank #(
  parameter int ROWS       = 4,
  parameter int COLUMNS    = 4,
  parameter int pkg_sz     = 40,
  parameter int fifo_depth = 4,
  parameter int FULL_MODE  = 0,
  parameter int AF_LVL     = fifo_depth - 1,
  localparam int NT        = ROWS*2 + COLUMNS*2,
  localparam int CW        = $clog2(fifo_depth + 1),
  localparam int PW        = $clog2(fifo_depth)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push        [NT],
  input  logic [pkg_sz-1:0] data_in     [NT],
  input  logic              pop         [NT],
  output logic [pkg_sz-1:0] data_out    [NT],
  output logic              pndng       [NT],
  output logic              full        [NT],
  output logic              almost_full [NT],
  output logic [CW-1:0]     count       [NT],
  output logic [15:0]       drop_cnt    [NT],
  output logic              underflow   [NT]
);

  localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth);
  localparam logic          OVW_POL = (FULL_MODE != 0);

  logic [pkg_sz-1:0] mem_q   [NT][fifo_depth];
  logic [PW-1:0]     wp_q    [NT];
  logic [PW-1:0]     wp_d    [NT];
  logic [PW-1:0]     rp_q    [NT];
  logic [PW-1:0]     rp_d    [NT];
  logic [CW-1:0]     cnt_q   [NT];
  logic [CW-1:0]     cnt_d   [NT];
  logic [15:0]       drop_q  [NT];
  logic [15:0]       drop_d  [NT];
  logic              ufl_q   [NT];
  logic              ufl_d   [NT];
  logic              wr_en   [NT];
  logic              do_pop  [NT];
  logic              is_full [NT];
  logic              ovw     [NT];
  logic              drop_ev [NT];
  logic              grow    [NT];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < NT; i++) begin
      wp_d[i]    = wp_q[i];
      rp_d[i]    = rp_q[i];
      cnt_d[i]   = cnt_q[i];
      drop_d[i]  = drop_q[i];
      ufl_d[i]   = ufl_q[i];
      do_pop[i]  = pop[i] && (cnt_q[i] != '0);
      is_full[i] = (cnt_q[i] == DEPTH_C);
      // A pop on a full FIFO frees a slot, so the push goes in without a drop.
      wr_en[i]   = push[i] && (!is_full[i] || do_pop[i] || OVW_POL);
      ovw[i]     = push[i] && is_full[i] && !do_pop[i] && OVW_POL;
      drop_ev[i] = push[i] && is_full[i] && !do_pop[i];
      grow[i]    = wr_en[i] && !ovw[i];

      if (wr_en[i])
        wp_d[i] = wp_q[i] + PW'(1);
      if (do_pop[i] || ovw[i])
        rp_d[i] = rp_q[i] + PW'(1);
      if (grow[i] && !do_pop[i])
        cnt_d[i] = cnt_q[i] + CW'(1);
      else if (!grow[i] && do_pop[i])
        cnt_d[i] = cnt_q[i] - CW'(1);
      if (drop_ev[i])
        drop_d[i] = sat_inc(drop_q[i]);
      if (pop[i] && (cnt_q[i] == '0))
        ufl_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NT; i++) begin
        wp_q[i]   <= '0;
        rp_q[i]   <= '0;
        cnt_q[i]  <= '0;
        drop_q[i] <= '0;
        ufl_q[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NT; i++) begin
        wp_q[i]   <= wp_d[i];
        rp_q[i]   <= rp_d[i];
        cnt_q[i]  <= cnt_d[i];
        drop_q[i] <= drop_d[i];
        ufl_q[i]  <= ufl_d[i];
      end
    end
  end

  // Payload storage keeps its contents across reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NT; i++) begin
      if (wr_en[i] && !reset)
        mem_q[i][wp_q[i]] <= data_in[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NT; i++) begin
      data_out[i]    = mem_q[i][rp_q[i]];
      pndng[i]       = (cnt_q[i] != '0);
      full[i]        = (cnt_q[i] == DEPTH_C);
      almost_full[i] = (int'(cnt_q[i]) >= AF_LVL);
      count[i]       = cnt_q[i];
      drop_cnt[i]    = drop_q[i];
      underflow[i]   = ufl_q[i];
    end
  end

endmodule

// File: doc/mesh_term_fifo_bank.md
MESH_TERM_FIFO_BANK -- requirements
Module: mesh_term_fifo_bank

Interface
REQ-001 Parameters SHALL be:
- ROWS, default 4, mesh rows.
- COLUMNS, default 4, mesh columns.
- pkg_sz, default 40, packet width in bits.
- fifo_depth, default 4, entries per channel; power of two, at least 2.
- FULL_MODE, default 0, full policy: 0 = reject newest, 1 = overwrite oldest.
- AF_LVL, default fifo_depth-1, almost-full threshold.
REQ-002 NT = ROWS*2+COLUMNS*2 SHALL be the channel count; every per-channel port is an unpacked array [NT].
REQ-003 Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- push[NT]  in  1  write request.
- data_in[NT]  in  pkg_sz  write data.
- pop[NT]  in  1  read acknowledge for the current head.
- data_out[NT]  out  pkg_sz  head entry (first-word fall-through).
- pndng[NT]  out  1  channel non-empty.
- full[NT]  out  1  count == fifo_depth.
- almost_full[NT]  out  1  count >= AF_LVL.
- count[NT]  out  $clog2(fifo_depth+1)  occupancy.
- drop_cnt[NT]  out  16  packets lost to the full policy; saturating.
- underflow[NT]  out  1  sticky flag: pop seen while empty.

Function
REQ-004 Each channel SHALL be an independent circular FIFO with write pointer, read pointer and occupancy count; channels share no state.
REQ-005 Pointers SHALL wrap modulo fifo_depth.
REQ-006 A push accepted at edge t SHALL give pndng=1 and valid data_out after that edge; latency is 1 cycle and there is no same-cycle bypass.
REQ-007 data_out SHALL equal the head entry whenever pndng=1; it is don't-care while pndng=0.
REQ-008 A pop with pndng=1 SHALL retire the head at the edge; the next entry appears on data_out after that edge.
REQ-009 A pop with pndng=0 SHALL be ignored and SHALL set underflow; underflow stays set until reset.
REQ-010 Push and pop together with 0<count<fifo_depth SHALL both succeed; count is unchanged.
REQ-011 Push and pop together with count==0 SHALL accept the push and ignore the pop; underflow is set.
REQ-012 Push and pop together with count==fifo_depth SHALL both succeed; count is unchanged and no drop is recorded.
REQ-013 Push without pop at count==fifo_depth with FULL_MODE=0 SHALL discard the incoming packet, leave the FIFO unchanged, and increment drop_cnt.
REQ-014 Push without pop at count==fifo_depth with FULL_MODE=1 SHALL overwrite the oldest entry and advance both pointers; count stays at fifo_depth and drop_cnt increments.
REQ-015 drop_cnt SHALL saturate at 16'hFFFF.
REQ-016 full, almost_full and pndng SHALL be decoded from the registered count and carry no combinational path from push or pop.
REQ-017 Storage SHALL not be cleared by reset; only pointers, counts and flags are reset.

Reset
REQ-018 While reset=1 at an edge, each channel SHALL set:
- pointers=0, count=0
- pndng=0, full=0, almost_full=0 (1 if AF_LVL==0)
- drop_cnt=0, underflow=0
REQ-019 reset SHALL take priority over push and pop in the same cycle; an in-flight push is lost and is not counted as a drop.
REQ-020 A reset asserted mid-operation SHALL discard all queued packets; the first push after reset deasserts is the new head.

Verification
REQ-021 The bench SHALL cover these scenarios (FULL_MODE as noted):
- Basic, mode 0: push A1..A3 on ch0 and pop 3 -> data_out A1,A2,A3 in order; count 1,2,3,2,1,0; pndng falls after the third pop.
- Reject, mode 0, depth 4: push 5 with no pops -> full=1, drop_cnt=1; pops return entries 1..4.
- Overwrite, mode 1, depth 4: push P1..P6 with no pops -> drop_cnt=2, count=4; pops return P3,P4,P5,P6.
- Full boundary: at count=4, push and pop in one cycle -> count stays 4, drop_cnt stays 0, head advances one entry.
- Underflow and isolation: pop on empty ch5 while pushing ch6 -> underflow[5]=1, other underflow flags 0, ch6 count=1.
- Mid-operation reset: ch0..ch(NT-1) hold 3 entries each; reset for 1 cycle together with a push -> all counts 0, pndng 0, drop_cnt 0.
